axis_frame_len_limit: RTL and testbench

- AXI4-Stream frame length limiter placed directly downstream of the frame FIFO's master port.
- Counts bytes per frame and truncates any frame longer than the runtime limit max_len. The truncated frame is emitted with tlast and a bad-frame tuser. Leftover input beats are consumed and discarded.
- Emits one length/status pulse per output frame; fully pipelined, one beat per cycle.

---
 rtl/axis_len_pkg.sv | 34 +++
 rtl/axis_frame_len_limit_if.sv | 29 ++
 rtl/axis_skid_reg.sv | 47 ++++
 rtl/axis_frame_len_limit.sv | 202 ++++++++++++++++++++
 tb/tb_axis_frame_len_limit.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_len_pkg.sv
// rtl/axis_len_pkg.sv - shared state type and tkeep helpers for the frame length limiter
// Purpose: state enum for the limiter FSM, byte popcount and contiguous keep-mask helpers.
// Ports: none (package).
package axis_len_pkg;

    // Widest tkeep the helpers handle; callers zero-extend narrower keeps.
    localparam int MAX_KEEP = 64;

    typedef enum logic {
        PASS = 1'b0,
        DROP = 1'b1
    } state_t;

    // Number of set bits in a tkeep vector.
    function automatic logic [7:0] popcount(input logic [MAX_KEEP-1:0] keep);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < MAX_KEEP; i++) begin
            n = n + {7'd0, keep[i]};
        end
        return n;
    endfunction

    // (1 << n) - 1, clipped to kw bits.
    function automatic logic [MAX_KEEP-1:0] mask(input int unsigned n, input int unsigned kw);
        logic [MAX_KEEP-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_KEEP; i++) begin
            m[i] = (i < n) && (i < kw);
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_frame_len_limit_if.sv
// rtl/axis_frame_len_limit_if.sv - AXI4-Stream bundle used by the frame length limiter
// Purpose: groups tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser of one stream.
// Ports: master drives payload and tvalid, receives tready; slave is the mirror.
interface axis_frame_len_limit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_skid_reg.sv
// rtl/axis_skid_reg.sv - 2-entry register slice with registered input ready
// Purpose: one-cycle-latency, full-throughput pipeline stage for a packed stream payload.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready upstream;
//        out_data/out_valid/out_ready downstream.
module axis_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             in_fire;

    assign in_fire = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b0;
        end else if (out_ready || !out_valid) begin
            // Output register is free: refill from skid first, else from input.
            out_valid <= skid_valid || in_fire;
            if (skid_valid) begin
                out_data <= skid_data;
            end else if (in_fire) begin
                out_data <= in_data;
            end
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (in_fire) begin
            // Stalled with a beat in flight: park it so ready can stay registered.
            skid_data  <= in_data;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
        end else begin
            in_ready <= !skid_valid;
        end
    end
endmodule

// File: rtl/axis_frame_len_limit.sv
// rtl/axis_frame_len_limit.sv - AXI4-Stream per-frame byte limiter with truncation
// Purpose: counts bytes per frame, cuts frames longer than max_len (tlast + bad tuser),
//          discards the remainder, and reports length/truncation per output frame.
// Ports: clk, rst (sync, active-high); s_axis input stream; m_axis output stream;
//        max_len byte limit (0 = unlimited, sampled on first beat);
//        status_valid/status_frame_len/status_truncated per-frame report;
//        status_trunc_count truncated-frame counter (AXIS_FRAME_LEN_LIMIT_STATS_EN, else 0).
module axis_frame_len_limit
    import axis_len_pkg::*;
#(
    parameter int                    DATA_WIDTH           = 32,
    parameter bit                    KEEP_ENABLE          = (DATA_WIDTH > 8),
    parameter int                    KEEP_WIDTH           = DATA_WIDTH / 8,
    parameter int                    ID_WIDTH             = 8,
    parameter int                    DEST_WIDTH           = 8,
    parameter int                    USER_WIDTH           = 1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = USER_WIDTH'(1),
    parameter int                    LEN_WIDTH            = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_frame_len_limit_if.slave  s_axis,
    axis_frame_len_limit_if.master m_axis,
    input  logic [LEN_WIDTH-1:0] max_len,
    output logic                 status_valid,
    output logic [LEN_WIDTH-1:0] status_frame_len,
    output logic                 status_truncated,
    output logic [31:0]          status_trunc_count
);
    localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

    state_t               state, state_n;
    logic [LEN_WIDTH-1:0] cnt, cnt_n, lim, lim_n;
    logic                 first, first_n;

    logic [MAX_KEEP-1:0]  keep_ext, cut_mask;
    logic [LEN_WIDTH:0]   beat_bytes, sum;
    logic [LEN_WIDTH-1:0] cur_lim, cur_cnt;
    logic                 over, fire;

    logic [DATA_WIDTH-1:0] b_data;
    logic [KEEP_WIDTH-1:0] b_keep;
    logic                  b_last, b_trunc;
    logic [USER_WIDTH-1:0] b_user;

    logic          skid_in_valid, skid_in_ready;
    logic [PW-1:0] skid_in, skid_out;

    logic [DATA_WIDTH-1:0] o_data;
    logic [KEEP_WIDTH-1:0] o_keep;
    logic                  o_last, o_trunc, o_valid;
    logic [ID_WIDTH-1:0]   o_id;
    logic [DEST_WIDTH-1:0] o_dest;
    logic [USER_WIDTH-1:0] o_user;

    // In DROP nothing enters the skid, so input is drained regardless of its fill.
    assign s_axis.tready = (state == DROP) || skid_in_ready;
    assign fire          = s_axis.tvalid && s_axis.tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PASS;
            cnt   <= '0;
            lim   <= '0;
            first <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            lim   <= lim_n;
            first <= first_n;
        end
    end

    always_comb begin
        keep_ext = '0;
        keep_ext[KEEP_WIDTH-1:0] = KEEP_ENABLE ? s_axis.tkeep : {KEEP_WIDTH{1'b1}};
        beat_bytes = {{(LEN_WIDTH-7){1'b0}}, popcount(keep_ext)};
        cur_lim    = first ? max_len : lim;
        cur_cnt    = first ? '0 : cnt;
        sum        = {1'b0, cur_cnt} + beat_bytes;
        over       = (cur_lim != '0) && (sum > {1'b0, cur_lim});
        cut_mask   = mask(32'(cur_lim - cur_cnt), KEEP_WIDTH);

        state_n       = state;
        cnt_n         = cnt;
        lim_n         = lim;
        first_n       = first;
        b_data        = s_axis.tdata;
        b_keep        = keep_ext[KEEP_WIDTH-1:0];
        b_last        = s_axis.tlast;
        b_user        = s_axis.tuser;
        b_trunc       = 1'b0;
        skid_in_valid = 1'b0;

        if (fire) begin
            if (state == PASS) begin
                skid_in_valid = 1'b1;
                lim_n         = cur_lim;
                first_n       = 1'b0;
                if (over) begin
                    // Cut here. When the limit was already reached exactly on the
                    // previous beat this becomes the zero-byte closing beat.
                    b_keep  = cut_mask[KEEP_WIDTH-1:0];
                    b_last  = 1'b1;
                    b_user  = USER_BAD_FRAME_VALUE;
                    b_trunc = 1'b1;
                    if (cur_cnt == cur_lim) begin
                        b_data = '0;
                    end
                    cnt_n = '0;
                    if (s_axis.tlast) begin
                        first_n = 1'b1;
                    end else begin
                        state_n = DROP;
                    end
                end else if (s_axis.tlast) begin
                    cnt_n   = '0;
                    first_n = 1'b1;
                end else begin
                    cnt_n = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
                end
            end else if (s_axis.tlast) begin
                state_n = PASS;
                first_n = 1'b1;
            end
        end
    end

    // The trailing bit marks a beat that was cut, independent of upstream tuser.
    assign skid_in = {b_data, b_keep, b_last, s_axis.tid, s_axis.tdest, b_user, b_trunc};

    axis_skid_reg #(.WIDTH(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (skid_in),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .out_data  (skid_out),
        .out_valid (o_valid),
        .out_ready (m_axis.tready)
    );

    assign {o_data, o_keep, o_last, o_id, o_dest, o_user, o_trunc} = skid_out;
    assign m_axis.tdata  = o_data;
    assign m_axis.tkeep  = o_keep;
    assign m_axis.tvalid = o_valid;
    assign m_axis.tlast  = o_last;
    assign m_axis.tid    = o_id;
    assign m_axis.tdest  = o_dest;
    assign m_axis.tuser  = o_user;

    // Output-side byte count: reflects what actually left, including cut keeps.
    logic [LEN_WIDTH-1:0] out_len, out_sat;
    logic [LEN_WIDTH:0]   out_sum;
    logic [MAX_KEEP-1:0]  okeep_ext;
    logic                 m_fire;

    assign m_fire = o_valid && m_axis.tready;

    always_comb begin
        okeep_ext = '0;
        okeep_ext[KEEP_WIDTH-1:0] = o_keep;
        out_sum = {1'b0, out_len} + {{(LEN_WIDTH-7){1'b0}}, popcount(okeep_ext)};
        out_sat = out_sum[LEN_WIDTH] ? '1 : out_sum[LEN_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_len          <= '0;
            status_valid     <= 1'b0;
            status_frame_len <= '0;
            status_truncated <= 1'b0;
        end else begin
            status_valid <= 1'b0;
            if (m_fire) begin
                if (o_last) begin
                    out_len          <= '0;
                    status_valid     <= 1'b1;
                    status_frame_len <= out_sat;
                    status_truncated <= o_trunc;
                end else begin
                    out_len <= out_sat;
                end
            end
        end
    end

`ifdef AXIS_FRAME_LEN_LIMIT_STATS_EN
    logic [31:0] trunc_count;
    always_ff @(posedge clk) begin
        if (rst) begin
            trunc_count <= '0;
        end else if (status_valid && status_truncated && (trunc_count != 32'hFFFF_FFFF)) begin
            trunc_count <= trunc_count + 32'd1;
        end
    end
    assign status_trunc_count = trunc_count;
`else
    assign status_trunc_count = '0;
`endif

endmodule

// File: tb/tb_axis_frame_len_limit.sv
// tb/tb_axis_frame_len_limit.sv - scoreboard bench for axis_frame_len_limit
module tb_axis_frame_len_limit;
    localparam int DW = 32, KW = 4, IW = 8, DSW = 8, UW = 1, LW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [LW-1:0] max_len = '0;
    logic          status_valid;
    logic [LW-1:0] status_frame_len;
    logic          status_truncated;
    logic [31:0]   status_trunc_count;

    axis_frame_len_limit_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW),
                              .DEST_WIDTH(DSW), .USER_WIDTH(UW)) s_axis ();
    axis_frame_len_limit_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW),
                              .DEST_WIDTH(DSW), .USER_WIDTH(UW)) m_axis ();

    axis_frame_len_limit #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW),
        .USER_WIDTH(UW), .USER_BAD_FRAME_VALUE(1'b1), .LEN_WIDTH(LW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis             (s_axis),
        .m_axis             (m_axis),
        .max_len            (max_len),
        .status_valid       (status_valid),
        .status_frame_len   (status_frame_len),
        .status_truncated   (status_truncated),
        .status_trunc_count (status_trunc_count)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [7:0]  id;
        logic [7:0]  dest;
        logic        user;
        int          acc;
    } beat_t;

    typedef struct {
        logic [15:0] len;
        logic        trunc;
    } stat_t;

    beat_t exp_q[$];
    stat_t stat_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    trunc_total = 0;
    bit    check_lat = 1'b0;
    bit    rand_ready = 1'b0;
    bit    hold_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [3:0] kmask(input int n);
        logic [3:0] one;
        one = 4'd1;
        if (n >= 4) return 4'hF;
        return 4'((one << n) - 4'd1);
    endfunction

    // Monitor / scoreboard
    initial begin
        beat_t       e;
        stat_t       st;
        bit          p_stall;
        logic [63:0] p_vec, vec;
        p_stall = 1'b0;
        p_vec   = '0;
        m_axis.tready = 1'b1;
        forever begin
            @(negedge clk);
            m_axis.tready = hold_ready ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            vec = {9'd0, m_axis.tvalid, m_axis.tdata, m_axis.tkeep, m_axis.tlast,
                   m_axis.tid, m_axis.tdest, m_axis.tuser};
            if (rst) begin
                p_stall = 1'b0;
            end else begin
                if (p_stall) chk("stall_stable", vec, p_vec);
                if (m_axis.tvalid && m_axis.tready) begin
                    if (exp_q.size() == 0) begin
                        chk("beat_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", vec, {9'd0, 1'b1, e.data, e.keep, e.last, e.id, e.dest, e.user});
                        if (check_lat) chk("latency", 64'(cyc - e.acc), 64'd1);
                    end
                end
                if (status_valid) begin
                    if (stat_q.size() == 0) begin
                        chk("status_unexpected", 64'd1, 64'd0);
                    end else begin
                        st = stat_q.pop_front();
                        chk("status", {47'd0, status_frame_len, status_truncated},
                            {47'd0, st.len, st.trunc});
                    end
                end
                p_stall = m_axis.tvalid && !m_axis.tready;
                p_vec   = vec;
            end
        end
    end

    task automatic finish_now();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Drive one frame; the reference result is derived from the byte-limit rules.
    task automatic send_frame(input int n, input logic [15:0] lim, input bit full,
                              input bit gaps, input bit chg);
        logic [31:0] d[8];
        int          b[8];
        logic        u[8];
        beat_t       ob[8];
        logic [7:0]  id, dest;
        int          e, outn, g;
        bit          tr;
        id   = 8'($urandom);
        dest = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            d[i] = $urandom;
            b[i] = full ? 4 : $urandom_range(1, 4);
            u[i] = 1'($urandom_range(0, 1));
        end
        e = 0; outn = 0; tr = 1'b0;
        for (int i = 0; i < n; i++) begin
            ob[i].id = id; ob[i].dest = dest; ob[i].acc = 0;
            if (lim == 0 || e + b[i] <= int'(lim)) begin
                ob[i].data = d[i]; ob[i].keep = kmask(b[i]);
                ob[i].last = (i == n - 1); ob[i].user = u[i];
                e += b[i];
                outn = i + 1;
            end else begin
                ob[i].data = (e == int'(lim)) ? 32'd0 : d[i];
                ob[i].keep = kmask(int'(lim) - e);
                ob[i].last = 1'b1; ob[i].user = 1'b1;
                e = int'(lim); tr = 1'b1;
                outn = i + 1;
                break;
            end
        end
        max_len = lim;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    s_axis.tvalid = 1'b0;
                    @(negedge clk);
                end
            end
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = d[i];
            s_axis.tkeep  = kmask(b[i]);
            s_axis.tlast  = (i == n - 1);
            s_axis.tid    = id;
            s_axis.tdest  = dest;
            s_axis.tuser  = u[i];
            g = 0;
            while (!s_axis.tready) begin
                @(negedge clk);
                g++;
                if (g > 500) begin
                    chk("input_ready_timeout", 64'd0, 64'd1);
                    finish_now();
                end
            end
            if (i < outn) begin
                ob[i].acc = cyc;
                exp_q.push_back(ob[i]);
            end
            if (i == outn - 1) begin
                stat_q.push_back('{len: 16'(e), trunc: tr});
                if (tr) trunc_total++;
            end
            @(negedge clk);
            if (chg) max_len = 16'($urandom_range(0, 20));
        end
        s_axis.tvalid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || stat_q.size() != 0) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk("drain_beats_left", 64'(exp_q.size()), 64'd0);
        chk("drain_status_left", 64'(stat_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] want_tc;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '0;
        s_axis.tlast  = 1'b0;
        s_axis.tid    = '0;
        s_axis.tdest  = '0;
        s_axis.tuser  = '0;
        repeat (3) @(negedge clk);
        chk("reset_m_tvalid", 64'(m_axis.tvalid), 64'd0);
        chk("reset_s_tready", 64'(s_axis.tready), 64'd0);
        chk("reset_status_valid", 64'(status_valid), 64'd0);
        chk("reset_status_len", 64'(status_frame_len), 64'd0);
        chk("reset_status_trunc", 64'(status_truncated), 64'd0);
        chk("reset_trunc_count", 64'(status_trunc_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_s_tready", 64'(s_axis.tready), 64'd1);

        // Directed frames, back-to-back, ready held high, latency checked.
        check_lat = 1'b1;
        send_frame(5, 16'd0, 1'b1, 1'b0, 1'b0);
        send_frame(4, 16'd10, 1'b1, 1'b0, 1'b0);
        send_frame(3, 16'd8, 1'b1, 1'b0, 1'b0);
        send_frame(1, 16'd6, 1'b1, 1'b0, 1'b0);
        send_frame(2, 16'd6, 1'b1, 1'b0, 1'b0);
        drain();
        check_lat = 1'b0;

        // Randomized traffic with backpressure and mid-frame limit changes.
        rand_ready = 1'b1;
        for (int f = 0; f < 200; f++) begin
            send_frame($urandom_range(1, 6),
                       ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 20)),
                       1'b0, 1'b1, 1'b1);
        end
        drain();
        rand_ready = 1'b0;
`ifdef AXIS_FRAME_LEN_LIMIT_STATS_EN
        want_tc = 32'(trunc_total);
`else
        want_tc = 32'd0;
`endif
        chk("trunc_count", 64'(status_trunc_count), 64'(want_tc));

        // Reset while beat 1 sits stalled in the output stage and beat 2 is offered.
        hold_ready = 1'b1;
        repeat (2) @(negedge clk);
        max_len = 16'd8;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 32'hAAAA_0001;
        s_axis.tkeep  = 4'hF;
        s_axis.tlast  = 1'b0;
        chk("pre_rst_ready", 64'(s_axis.tready), 64'd1);
        @(negedge clk);
        s_axis.tdata = 32'hAAAA_0002;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_m_tvalid", 64'(m_axis.tvalid), 64'd0);
        chk("midrst_s_tready", 64'(s_axis.tready), 64'd0);
        chk("midrst_trunc_count", 64'(status_trunc_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        s_axis.tvalid = 1'b0;
        hold_ready = 1'b0;
        @(negedge clk);
        chk("after_rst_ready", 64'(s_axis.tready), 64'd1);
        check_lat = 1'b1;
        send_frame(3, 16'd8, 1'b1, 1'b0, 1'b0);
        drain();

        finish_now();
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        failures++;
        finish_now();
    end
endmodule
